dff_response_checker: RTL and testbench

DFF_RESPONSE_CHECKER -- requirements
Module: dff_response_checker

---
 rtl/dff_response_checker.sv | 125 ++++++++++++
 tb/tb_dff_response_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_response_checker.sv
// Checks a single DUT flip-flop against a one-cycle-delayed prediction of d/dut_rst.
// Optional build macro DFF_CHK_STOP_ON_ERR_EN: end the run at the first mismatch.
//
// state | meaning
// IDLE  | waiting for start, no run active
// ARM   | one priming cycle after an accepted start
// CHECK | comparing q against exp_q on every qualified edge
// DONE  | run finished, results held until the next accepted start
module dff_response_checker #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             dut_rst,
   input  logic             q,
   input  logic             start,
   input  logic [CNT_W-1:0] num_checks,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_fail_idx
);

   typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] target;
   logic             exp_q;
   logic             pred_ok;

   logic             qual;
   logic             mism;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] err_inc;
   logic             last;
   logic             stop_now;

   // Prediction follows the DUT with a one-edge lag; pred_ok drops for the edge after a dut_rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q   <= 1'b0;
         pred_ok <= 1'b0;
      end else begin
         exp_q   <= dut_rst ? 1'b0 : d;
         pred_ok <= ~dut_rst;
      end
   end

   always_comb begin
      qual    = pred_ok & ~dut_rst;
      mism    = qual & (q != exp_q);
      cnt_inc = chk_cnt + 1'b1;
      err_inc = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
      last    = (cnt_inc == target);
`ifdef DFF_CHK_STOP_ON_ERR_EN
      stop_now = last | mism;
`else
      stop_now = last;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         target         <= '0;
         chk_cnt        <= '0;
         err_cnt        <= '0;
         first_fail_idx <= '1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  target         <= num_checks;
                  chk_cnt        <= '0;
                  err_cnt        <= '0;
                  first_fail_idx <= '1;
                  if (num_checks == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= ARM;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            ARM: begin
               state <= CHECK;
            end
            CHECK: begin
               if (qual) begin
                  chk_cnt <= cnt_inc;
                  if (mism) begin
                     err_cnt <= err_inc;
                     if (err_cnt == '0)
                        first_fail_idx <= chk_cnt;
                  end
                  if (stop_now) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= ~mism & (err_cnt == '0);
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker driving a behavioural DFF with optional q inversion.
// Expected results follow DFF_CHK_STOP_ON_ERR_EN when the bench is built with that macro.
module tb_dff_response_checker;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             d = 1'b0;
   logic             dut_rst = 1'b0;
   logic             q;
   logic             start = 1'b0;
   logic [CNT_W-1:0] num_checks = '0;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] chk_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] first_fail_idx;

   logic dq = 1'b0;
   logic inj = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) dq <= dut_rst ? 1'b0 : d;
   assign q = dq ^ inj;

   dff_response_checker #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .d(d), .dut_rst(dut_rst), .q(q),
      .start(start), .num_checks(num_checks),
      .busy(busy), .done(done), .pass(pass),
      .chk_cnt(chk_cnt), .err_cnt(err_cnt), .first_fail_idx(first_fail_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      d = 1'($urandom_range(0, 1));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic kick(input logic [CNT_W-1:0] n);
      start = 1'b1;
      num_checks = n;
      tick();
      start = 1'b0;
      num_checks = 16'h0003;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ticks(3);
      checks++;
      if ({busy, done, pass} !== 3'b000 || chk_cnt !== 16'd0 || err_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_values got busy=%b done=%b pass=%b chk=%0d err=%0d ffi=%h want 0 0 0 0 0 ffff",
                  busy, done, pass, chk_cnt, err_cnt, first_fail_idx);
      end
      rst = 1'b0;
      ticks(2);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_release got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_clean_run();
      kick(16'd8);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL clean_busy got %b want 1", busy);
      end
      ticks(8);
      checks++;
      if (done !== 1'b0 || chk_cnt !== 16'd7) begin
         errors++;
         $display("FAIL clean_before_end got done=%b chk=%0d want 0 7", done, chk_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || chk_cnt !== 16'd8 || err_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         errors++;
         $display("FAIL clean_result got done=%b busy=%b pass=%b chk=%0d err=%0d ffi=%h want 1 0 1 8 0 ffff",
                  done, busy, pass, chk_cnt, err_cnt, first_fail_idx);
      end
   endtask

   task automatic test_done_hold();
      inj = 1'b1;
      ticks(2);
      inj = 1'b0;
      dut_rst = 1'b1;
      tick();
      dut_rst = 1'b0;
      ticks(2);
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || chk_cnt !== 16'd8 || err_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         errors++;
         $display("FAIL done_hold got done=%b pass=%b chk=%0d err=%0d ffi=%h want 1 1 8 0 ffff",
                  done, pass, chk_cnt, err_cnt, first_fail_idx);
      end
   endtask

   task automatic test_single_error();
      kick(16'd10);
      ticks(4);
      inj = 1'b1;
      tick();
      inj = 1'b0;
      checks++;
      if (err_cnt !== 16'd1 || first_fail_idx !== 16'd3 || chk_cnt !== 16'd4) begin
         errors++;
         $display("FAIL err_latency got err=%0d ffi=%0d chk=%0d want 1 3 4", err_cnt, first_fail_idx, chk_cnt);
      end
`ifdef DFF_CHK_STOP_ON_ERR_EN
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_on_err got done=%b pass=%b busy=%b want 1 0 0", done, pass, busy);
      end
      ticks(3);
      checks++;
      if (chk_cnt !== 16'd4 || err_cnt !== 16'd1 || done !== 1'b1) begin
         errors++;
         $display("FAIL stop_frozen got chk=%0d err=%0d done=%b want 4 1 1", chk_cnt, err_cnt, done);
      end
`else
      ticks(5);
      checks++;
      if (done !== 1'b0 || chk_cnt !== 16'd9) begin
         errors++;
         $display("FAIL err_run_continues got done=%b chk=%0d want 0 9", done, chk_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || chk_cnt !== 16'd10 || err_cnt !== 16'd1 || first_fail_idx !== 16'd3) begin
         errors++;
         $display("FAIL err_result got done=%b pass=%b chk=%0d err=%0d ffi=%0d want 1 0 10 1 3",
                  done, pass, chk_cnt, err_cnt, first_fail_idx);
      end
`endif
   endtask

   task automatic test_dut_rst_gap();
      kick(16'd6);
      ticks(3);
      dut_rst = 1'b1;
      ticks(2);
      dut_rst = 1'b0;
      checks++;
      if (chk_cnt !== 16'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL gap_skipped got chk=%0d busy=%b want 2 1", chk_cnt, busy);
      end
      tick();
      checks++;
      if (chk_cnt !== 16'd2) begin
         errors++;
         $display("FAIL gap_priming got chk=%0d want 2", chk_cnt);
      end
      ticks(3);
      checks++;
      if (done !== 1'b0 || chk_cnt !== 16'd5) begin
         errors++;
         $display("FAIL gap_before_end got done=%b chk=%0d want 0 5", done, chk_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || chk_cnt !== 16'd6 || err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL gap_result got done=%b pass=%b chk=%0d err=%0d want 1 1 6 0", done, pass, chk_cnt, err_cnt);
      end
   endtask

   task automatic test_zero_checks();
      kick(16'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || chk_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         errors++;
         $display("FAIL zero_checks got done=%b busy=%b pass=%b chk=%0d ffi=%h want 1 0 1 0 ffff",
                  done, busy, pass, chk_cnt, first_fail_idx);
      end
   endtask

   task automatic test_start_while_busy();
      kick(16'd5);
      ticks(2);
      start = 1'b1;
      num_checks = 16'd2;
      tick();
      start = 1'b0;
      ticks(3);
      checks++;
      if (done !== 1'b1 || chk_cnt !== 16'd5 || pass !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_ignored got done=%b chk=%0d pass=%b want 1 5 1", done, chk_cnt, pass);
      end
   endtask

   task automatic test_abort();
      kick(16'd10);
      ticks(5);
      checks++;
      if (chk_cnt !== 16'd4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_setup got chk=%0d busy=%b want 4 1", chk_cnt, busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, pass} !== 3'b000 || chk_cnt !== 16'd0 || err_cnt !== 16'd0 || first_fail_idx !== 16'hFFFF) begin
         errors++;
         $display("FAIL abort_async got busy=%b done=%b pass=%b chk=%0d err=%0d ffi=%h want 0 0 0 0 0 ffff",
                  busy, done, pass, chk_cnt, err_cnt, first_fail_idx);
      end
      ticks(2);
      rst = 1'b0;
      ticks(12);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || chk_cnt !== 16'd0) begin
         errors++;
         $display("FAIL abort_no_result got done=%b busy=%b chk=%0d want 0 0 0", done, busy, chk_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_done_hold();
      test_single_error();
      test_dut_rst_gap();
      test_zero_checks();
      test_start_while_busy();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
